// File: rtl/gi_aes_mixctl_if.sv
// Purpose: state/key request and mixed-state response handshakes of gi_aes_mixctl.
// Latency: none, wires only.
// Backpressure: valid/ready on both directions.
interface gi_aes_mixctl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport slave (
        input  in_valid, in_state, in_key, in_last, out_ready,
        output in_ready, out_valid, out_state
    );

    modport master (
        output in_valid, in_state, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_state
    );
endinterface

// File: rtl/gi_aes_mixctl.sv
// Purpose: one shared MixColumns+AddRoundKey column datapath sequenced over the 4 state columns.
// Latency: 4 cycles accept-to-out_valid, fixed regardless of data or in_last; 1 block per 5 cycles.
// Backpressure: result held in DONE until out_ready; in_ready reopens in that same cycle.
module gi_aes_mixctl (
    input  logic           clk,
    input  logic           reset_l,
    input  logic           clr,
    gi_aes_mixctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MIX = 2'd1, DONE = 2'd2} fsm_t;
    // Element [3] holds column 0 so columns map MSB-first like the bus.
    typedef logic [3:0][31:0] aes_state_t;

    fsm_t       st, st_nxt;
    logic [1:0] col;
    aes_state_t state_q, key_q, out_q;
    logic       last_q;
    logic       accept;
    logic [31:0] mix_in, mix_out, res_col;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_l) st <= IDLE;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (clr) begin
            st_nxt = IDLE;
        end else begin
            case (st)
                IDLE:    if (accept) st_nxt = MIX;
                MIX:     if (col == 2'd3) st_nxt = DONE;
                DONE:    if (bus.out_ready) st_nxt = accept ? MIX : IDLE;
                default: st_nxt = IDLE;
            endcase
        end
    end

    // The mix is always computed so timing and switching do not depend on in_last.
    always_comb begin
        bus.in_ready  = reset_l & ~clr & ((st == IDLE) | ((st == DONE) & bus.out_ready));
        bus.out_valid = (st == DONE);
        bus.out_state = out_q;
        accept        = bus.in_valid & bus.in_ready;
        mix_in        = state_q[2'd3 - col];
        mix_out       = mix_col(mix_in);
        res_col       = (last_q ? mix_in : mix_out) ^ key_q[2'd3 - col];
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            last_q  <= 1'b0;
            col     <= 2'd0;
        end else if (clr) begin
            col <= 2'd0;
        end else if (accept) begin
            state_q <= bus.in_state;
            key_q   <= bus.in_key;
            last_q  <= bus.in_last;
            col     <= 2'd0;
        end else if (st == MIX) begin
            out_q[2'd3 - col] <= res_col;
            col               <= col + 2'd1;
        end
    end
endmodule

// File: tb/tb_gi_aes_mixctl.sv
module tb_gi_aes_mixctl;
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic clr = 1'b0;

    gi_aes_mixctl_if bus();
    gi_aes_mixctl dut (.clk(clk), .reset_l(reset_l), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] V_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_MIX  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V_KEY  = {4{32'ha5a5a5a5}};
    localparam logic [127:0] V_BYP  = 128'h7eb6f6e0_57af87f9_a4a4a4a4_888394e9;
    localparam logic [127:0] V_MIXK = 128'h2be80419_3a79fd38_a4a4a4a4_e8db185d;

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                        input logic [127:0] e, input bit push, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_key   = k;
        bus.in_last  = l;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok && push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = -1;
        ok  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i - 1;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_state = V_IN; bus.in_key = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_state} !== {2'b00, 128'h0})
            $display("FAIL reset_outputs: got v=%b r=%b s=%h want v=0 r=0 s=0",
                     bus.out_valid, bus.in_ready, bus.out_state);
        else n_pass++;
        bus.in_valid = 1'b0;
        reset_l = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic run_one(input logic [127:0] s, input logic [127:0] k, input logic l,
                           input logic [127:0] e, input string name);
        bit ok;
        int lat;
        send(s, k, l, e, 1'b1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL %s_accept: got no accept want accept", name);
        else n_pass++;
        wait_valid(lat, ok);
        n_checks++;
        if (!ok || lat != 4) $display("FAIL %s_latency: got %0d want 4", name, lat);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0 || bus.out_state !== exp_q[0])
            $display("FAIL %s_data: got %h want %h", name, bus.out_state, e);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL %s_drain: got out_valid=%b want 0", name, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_fips();
        run_one(V_IN, 128'h0, 1'b0, V_MIX, "fips");
    endtask

    task automatic test_bypass();
        run_one(V_IN, V_KEY, 1'b1, V_BYP, "bypass");
    endtask

    task automatic test_back_to_back();
        logic [127:0] bs[3], bk[3], be[3];
        logic         bl[3];
        int acc[3];
        int idx = 0;
        int got = 0;
        bs = '{V_IN, V_IN, V_IN};
        bk = '{128'h0, V_KEY, V_KEY};
        bl = '{1'b0, 1'b1, 1'b0};
        be = '{V_MIX, V_BYP, V_MIXK};
        acc = '{0, 0, 0};
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            if (idx < 3) begin
                bus.in_valid = 1'b1; bus.in_state = bs[idx]; bus.in_key = bk[idx]; bus.in_last = bl[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_data: got %h want nothing", bus.out_state);
                else if (bus.out_state !== exp_q[0])
                    $display("FAIL b2b_data: got %h want %h", bus.out_state, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (idx > 0) begin
                    n_checks++;
                    if (bus.out_valid !== 1'b1) $display("FAIL b2b_ready_in_done: got out_valid=%b want 1", bus.out_valid);
                    else n_pass++;
                end
                acc[idx] = cyc;
                exp_q.push_back(be[idx]);
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != 3) $display("FAIL b2b_count: got %0d want 3", got);
        else n_pass++;
        n_checks++;
        if (acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5)
            $display("FAIL b2b_spacing: got %0d,%0d want 5,5", acc[1] - acc[0], acc[2] - acc[1]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        send(V_IN, V_KEY, 1'b0, V_MIXK, 1'b1, ok);
        wait_valid(lat, ok);
        n_checks++;
        if (!ok) $display("FAIL bp_valid: got timeout want out_valid");
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_state} !== {2'b10, V_MIXK})
                $display("FAIL bp_hold: got v=%b r=%b s=%h want v=1 r=0 s=%h",
                         bus.out_valid, bus.in_ready, bus.out_state, V_MIXK);
            else n_pass++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_release: got out_valid=%b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_clr();
        bit ok;
        bit seen = 1'b0;
        send(V_IN, 128'h0, 1'b0, V_MIX, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        bus.in_valid = 1'b1; bus.in_state = V_IN; bus.in_key = V_KEY; bus.in_last = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL clr_no_accept: got in_ready=%b want 0", bus.in_ready);
        else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL clr_idle: got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL clr_no_output: got out_valid seen=1 want 0");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        send(V_IN, V_KEY, 1'b0, V_MIXK, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_state} !== {2'b00, 128'h0})
            $display("FAIL rst_mix: got v=%b r=%b s=%h want v=0 r=0 s=0",
                     bus.out_valid, bus.in_ready, bus.out_state);
        else n_pass++;
        bus.in_valid = 1'b0;
        reset_l = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_mix_release: got %b want 1", bus.in_ready);
        else n_pass++;

        send(V_IN, V_KEY, 1'b1, V_BYP, 1'b0, ok);
        wait_valid(lat, ok);
        n_checks++;
        if (!ok || bus.out_state !== V_BYP)
            $display("FAIL rst_done_pre: got %h want %h", bus.out_state, V_BYP);
        else n_pass++;
        reset_l = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_state} !== {2'b00, 128'h0})
            $display("FAIL rst_done: got v=%b r=%b s=%h want v=0 r=0 s=0",
                     bus.out_valid, bus.in_ready, bus.out_state);
        else n_pass++;
        reset_l = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_done_release: got %b want 1", bus.in_ready);
        else n_pass++;
        run_one(V_IN, 128'h0, 1'b0, V_MIX, "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_state = '0;
        bus.in_key = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fips();
        test_bypass();
        test_back_to_back();
        test_backpressure();
        test_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
